// File: rtl/keep_one_in_n_mc.sv
// rtl/keep_one_in_n_mc.sv - keep one sample group or packet in N, 2-entry output skid buffer
// KEEP_ONE_IN_N_MC_STATS_EN adds the drop_cnt output and its saturating counter.
module keep_one_in_n_mc #(
  parameter int WIDTH  = 32,
  parameter int MAX_N  = 65535,
  parameter int NUM_CH = 1,
  localparam int NW    = $clog2(MAX_N + 1),
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NW-1:0]    n,
  input  logic             mode,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready
`ifdef KEEP_ONE_IN_N_MC_STATS_EN
  ,
  output logic [31:0]      drop_cnt
`endif
);

  logic [NW-1:0]    r_n, r_grp_cnt, r_pkt_cnt;
  logic             r_mode, r_in_pkt;
  logic [CW-1:0]    r_ch_idx;
  logic [WIDTH-1:0] r_data0, r_data1;
  logic             r_last0, r_last1;
  logic [1:0]       r_count;

  logic [NW-1:0] w_n_eff, w_grp_next, w_pkt_next;
  logic          w_cfg_chg, w_keep, w_full, w_acc, w_push, w_pop, w_ch_last, w_out_last;

  assign w_n_eff    = (n == '0) ? NW'(1) : n;
  // Config only follows the inputs between packets; a change restarts all counters.
  assign w_cfg_chg  = !r_in_pkt && ((w_n_eff != r_n) || (mode != r_mode));
  assign w_keep     = r_mode ? (r_pkt_cnt >= r_n) : (r_grp_cnt >= r_n);
  assign w_out_last = r_mode ? i_tlast : (i_tlast && (r_pkt_cnt >= r_n));
  assign w_ch_last  = (r_ch_idx == CW'(NUM_CH - 1));
  assign w_grp_next = (r_grp_cnt >= r_n) ? NW'(1) : r_grp_cnt + NW'(1);
  assign w_pkt_next = (r_pkt_cnt >= r_n) ? NW'(1) : r_pkt_cnt + NW'(1);

  assign w_full   = (r_count == 2'd2);
  assign i_tready = !w_keep || !w_full;
  assign w_acc    = i_tvalid && i_tready;
  assign w_push   = w_acc && w_keep;
  assign w_pop    = o_tvalid && o_tready;

  assign o_tvalid = (r_count != 2'd0);
  assign o_tdata  = r_data0;
  assign o_tlast  = r_last0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_n       <= NW'(1);
      r_mode    <= 1'b0;
      r_grp_cnt <= NW'(1);
      r_pkt_cnt <= NW'(1);
      r_ch_idx  <= '0;
      r_in_pkt  <= 1'b0;
    end else begin
      if (!r_in_pkt) begin
        r_n    <= w_n_eff;
        r_mode <= mode;
      end
      if (w_acc) r_in_pkt <= !i_tlast;
      if (w_cfg_chg) begin
        r_grp_cnt <= NW'(1);
        r_pkt_cnt <= NW'(1);
        r_ch_idx  <= '0;
      end else if (w_acc) begin
        r_ch_idx <= (i_tlast || w_ch_last) ? '0 : r_ch_idx + CW'(1);
        if (!r_mode && (w_ch_last || i_tlast)) r_grp_cnt <= w_grp_next;
        if (i_tlast) r_pkt_cnt <= w_pkt_next;
      end
    end
  end

  // Entry 0 is the output head; push and pop together only happen with one entry held.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data0 <= '0;
      r_data1 <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_data0 <= i_tdata;
            r_last0 <= w_out_last;
          end else begin
            r_data1 <= i_tdata;
            r_last1 <= w_out_last;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_data0 <= r_data1;
          r_last0 <= r_last1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          r_data0 <= i_tdata;
          r_last0 <= w_out_last;
        end
        default: ;
      endcase
    end
  end

`ifdef KEEP_ONE_IN_N_MC_STATS_EN
  logic [31:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) r_drop_cnt <= '0;
    else if (w_acc && !w_keep && (r_drop_cnt != 32'hFFFF_FFFF)) r_drop_cnt <= r_drop_cnt + 32'd1;
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_keep_one_in_n_mc.sv
// tb/tb_keep_one_in_n_mc.sv - directed self-checking bench for keep_one_in_n_mc
module tb_keep_one_in_n_mc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] n_val;
  logic        mode;
  logic [31:0] i_tdata;
  logic        i_tlast, i_tvalid, o_tready;

  logic        a_i_tready, a_o_tlast, a_o_tvalid;
  logic [31:0] a_o_tdata;
  logic        b_i_tready, b_o_tlast, b_o_tvalid;
  logic [31:0] b_o_tdata;
`ifdef KEEP_ONE_IN_N_MC_STATS_EN
  logic [31:0] a_drop_cnt, b_drop_cnt;
`endif

  int n_asserts = 0;
  int n_fail    = 0;
  int cap_d_a[$], cap_l_a[$], cap_d_b[$], cap_l_b[$];
  int exp_d[$], exp_l[$];

  always #5 clk = ~clk;

  keep_one_in_n_mc #(.WIDTH(32), .MAX_N(65535), .NUM_CH(1)) u_a (
    .clk(clk), .reset_n(reset_n), .n(n_val), .mode(mode),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(a_i_tready),
    .o_tdata(a_o_tdata), .o_tlast(a_o_tlast), .o_tvalid(a_o_tvalid), .o_tready(o_tready)
`ifdef KEEP_ONE_IN_N_MC_STATS_EN
    , .drop_cnt(a_drop_cnt)
`endif
  );

  keep_one_in_n_mc #(.WIDTH(32), .MAX_N(65535), .NUM_CH(2)) u_b (
    .clk(clk), .reset_n(reset_n), .n(n_val), .mode(mode),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(b_i_tready),
    .o_tdata(b_o_tdata), .o_tlast(b_o_tlast), .o_tvalid(b_o_tvalid), .o_tready(o_tready)
`ifdef KEEP_ONE_IN_N_MC_STATS_EN
    , .drop_cnt(b_drop_cnt)
`endif
  );

  always @(negedge clk) begin
    if (a_o_tvalid && o_tready) begin
      cap_d_a.push_back(int'(a_o_tdata));
      cap_l_a.push_back(int'(a_o_tlast));
    end
    if (b_o_tvalid && o_tready) begin
      cap_d_b.push_back(int'(b_o_tdata));
      cap_l_b.push_back(int'(b_o_tlast));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_stream(input string tag, input bit use_b);
    int cd[$];
    int cl[$];
    if (use_b) begin cd = cap_d_b; cl = cap_l_b; end
    else       begin cd = cap_d_a; cl = cap_l_a; end
    chk({tag, "_count"}, cd.size(), exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), (i < cd.size()) ? cd[i] : -1, exp_d[i]);
      chk($sformatf("%s_last%0d", tag, i), (i < cl.size()) ? cl[i] : -1, exp_l[i]);
    end
  endtask

  task automatic do_reset(input logic [15:0] nv, input logic mv);
    reset_n  = 1'b0;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    i_tdata  = '0;
    n_val    = nv;
    mode     = mv;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cap_d_a.delete(); cap_l_a.delete(); cap_d_b.delete(); cap_l_b.delete();
  endtask

  task automatic send(input int d, input logic l);
    int k;
    k = 0;
    i_tdata  = d;
    i_tlast  = l;
    i_tvalid = 1'b1;
    @(negedge clk);
    while (!a_i_tready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  initial begin
    o_tready = 1'b1;
    reset_n  = 1'b0;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    i_tdata  = '0;
    n_val    = 16'd4;
    mode     = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_o_tvalid", a_o_tvalid, 0);
    chk("rst_o_tdata", a_o_tdata, 0);
    chk("rst_o_tlast", a_o_tlast, 0);
`ifdef KEEP_ONE_IN_N_MC_STATS_EN
    chk("rst_drop_cnt", a_drop_cnt, 0);
`endif

    // one in four, single channel, four packets of four
    do_reset(16'd4, 1'b0);
    chk("r033_i_tready_idle", a_i_tready, 1);
    for (int i = 0; i < 16; i++) begin
      send(i, (i % 4) == 3);
      if (i == 3) begin
        chk("r033_latency_valid", a_o_tvalid, 1);
        chk("r033_latency_data", a_o_tdata, 3);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    exp_d = '{3, 7, 11, 15};
    exp_l = '{0, 0, 0, 1};
    chk_stream("r033", 1'b0);
`ifdef KEEP_ONE_IN_N_MC_STATS_EN
    chk("r038_drop_cnt", a_drop_cnt, 12);
`endif

    // two channels grouped, one in three
    do_reset(16'd3, 1'b0);
    for (int i = 0; i < 12; i++) send(i, i == 11);
    repeat (4) @(posedge clk);
    #1;
    exp_d = '{4, 5, 10, 11};
    exp_l = '{0, 0, 0, 0};
    chk_stream("r034", 1'b1);

    // whole-packet decimation
    do_reset(16'd3, 1'b1);
    for (int p = 0; p < 6; p++)
      for (int b = 0; b < 5; b++) send(p * 5 + b, b == 4);
    repeat (4) @(posedge clk);
    #1;
    exp_d = '{10, 11, 12, 13, 14, 25, 26, 27, 28, 29};
    exp_l = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    chk_stream("r035", 1'b0);
`ifdef KEEP_ONE_IN_N_MC_STATS_EN
    chk("r035_drop_cnt", a_drop_cnt, 20);
`endif

    // n changes mid-packet: takes effect only from the next packet
    do_reset(16'd2, 1'b0);
    send(0, 1'b0);
    send(1, 1'b0);
    n_val = 16'd5;
    send(2, 1'b0);
    send(3, 1'b0);
    send(4, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) send(100 + i, i == 9);
    repeat (4) @(posedge clk);
    #1;
    exp_d = '{1, 3, 104, 109};
    exp_l = '{0, 0, 0, 0};
    chk_stream("r036", 1'b0);

    // pass-all with backpressure: skid fills at two beats
    do_reset(16'd0, 1'b0);
    o_tready = 1'b0;
    send(200, 1'b0);
    send(201, 1'b0);
    i_tdata  = 202;
    i_tlast  = 1'b0;
    i_tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("r037_stall_tready%0d", c), a_i_tready, 0);
    end
    chk("r037_hold_valid", a_o_tvalid, 1);
    chk("r037_hold_data", a_o_tdata, 200);
    @(posedge clk);
    #1;
    o_tready = 1'b1;
    send(202, 1'b0);
    send(203, 1'b0);
    send(204, 1'b0);
    send(205, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    exp_d = '{200, 201, 202, 203, 204, 205};
    exp_l = '{0, 0, 0, 0, 0, 1};
    chk_stream("r037", 1'b0);

    // reset mid-stream discards the buffered beat
    do_reset(16'd4, 1'b0);
    o_tready = 1'b0;
    for (int i = 0; i < 6; i++) send(i, 1'b0);
    chk("r038_pre_valid", a_o_tvalid, 1);
    chk("r038_pre_data", a_o_tdata, 3);
`ifdef KEEP_ONE_IN_N_MC_STATS_EN
    chk("r038_pre_drop", a_drop_cnt, 5);
`endif
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("r038_rst_valid", a_o_tvalid, 0);
    chk("r038_rst_data", a_o_tdata, 0);
    chk("r038_rst_last", a_o_tlast, 0);
`ifdef KEEP_ONE_IN_N_MC_STATS_EN
    chk("r038_rst_drop", a_drop_cnt, 0);
`endif
    reset_n  = 1'b1;
    o_tready = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
